multiword_adder_seq: RTL and testbench

Multi-cycle sequencer that adds two wide operands (N*WORDS bits) by time-multiplexing a single N-bit full-adder slice, one word per clock, least-significant word first. The carry is chained between words through a register. It sits between a requester issuing start/operand pulses and a consumer of the wide sum. It trades WORDS cycles of latency for a single N-bit adder instead of a full-width ripple chain.

---
 rtl/multiword_adder_seq.sv | 95 +++++++++
 tb/tb_multiword_adder_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_adder_seq.sv
// ============================================================================
// Module   : multiword_adder_seq
// Purpose  : Wide unsigned adder that reuses one N-bit slice, one word/clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiword_adder_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N*WORDS-1:0] num1,
  input  logic [N*WORDS-1:0] num2,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [N*WORDS-1:0] sum,
  output logic             carry
);

  localparam int W  = N * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_psum;
  logic            r_carry;

  logic [N:0]      w_slice;
  logic [W-1:0]    w_psum_next;

  // Operands shift right and the partial sum fills from the top, so the single
  // slice always sees the current word at bit 0 and word i lands in slot i
  // once all WORDS slices have been added.
  assign w_slice     = {1'b0, r_a[N-1:0]} + {1'b0, r_b[N-1:0]} + {{N{1'b0}}, r_carry};
  assign w_psum_next = {w_slice[N-1:0], r_psum[W-1:N]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      carry   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= num1;
            r_b     <= num2;
            r_carry <= carry_in;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> N;
          r_b     <= r_b >> N;
          r_carry <= w_slice[N];
          r_psum  <= w_psum_next;
          r_idx   <= r_idx + IW'(1);
          if (r_idx == LAST_IDX) begin
            sum     <= w_psum_next;
            carry   <= w_slice[N];
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multiword_adder_seq.sv
// ============================================================================
// Module   : tb_multiword_adder_seq
// Purpose  : Self-checking bench for multiword_adder_seq against a 33-bit model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiword_adder_seq;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] num1;
  logic [W-1:0] num2;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  int checks;
  int failures;

  multiword_adder_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num1     (num1),
    .num2     (num2),
    .carry_in (carry_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry    (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference: plain wide addition, carry is bit W.
  function automatic logic [W:0] ref_add(logic [W-1:0] a, logic [W-1:0] b, logic ci);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge and count edges until done; returns latency and busy-cycle count.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        output int lat, output int busy_cnt);
    start = 1'b1; num1 = a; num2 = b; carry_in = ci;
    tick();
    start = 1'b0;
    lat = 0; busy_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      if (busy) busy_cnt++;
      tick();
      if (done) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; num1 = 32'hDEADBEEF; num2 = 32'h12345678; carry_in = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, done, sum, carry} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h carry=%b required 0/0/0/0", busy, done, sum, carry);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_start: busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_ripple();
    int lat, bc;
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, bc);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL ripple_latency: got=%0d required=4", lat); end
    checks++;
    if (bc !== 4) begin failures++; $display("FAIL ripple_busy_cycles: got=%0d required=4", bc); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ripple_busy_in_done: got=%b required=0", busy); end
    checks++;
    if (sum !== 32'h0 || carry !== 1'b1) begin
      failures++; $display("FAIL ripple_result: sum=%h carry=%b required 00000000/1", sum, carry);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL ripple_done_width: got=%b required=0", done); end
  endtask

  task automatic test_carry_in();
    int lat;
    start = 1'b1; num1 = 32'h12345678; num2 = 32'h11111111; carry_in = 1'b1;
    tick();
    start = 1'b0;
    tick();
    num1 = '0; num2 = '0; carry_in = 1'b0;
    lat = 0;
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (done) begin lat = c; break; end
    end
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL cin_latency: got=%0d required=4", lat); end
    checks++;
    if (sum !== 32'h2345678A || carry !== 1'b0) begin
      failures++; $display("FAIL cin_result: sum=%h carry=%b required 2345678a/0", sum, carry);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    int dones;
    start = 1'b1; num1 = 32'hFFFFFFFF; num2 = 32'h00000001; carry_in = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, carry} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_clear: busy=%b done=%b sum=%h carry=%b required 0/0/0/0", busy, done, sum, carry);
    end
    dones = 0;
    for (int c = 0; c < 4; c++) begin tick(); if (done) dones++; end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin tick(); if (done) dones++; end
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL reset_mid_no_done: got=%0d pulses required=0", dones); end
    run_op(32'h00000001, 32'h00000001, 1'b0, lat, bc);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL reset_mid_after_latency: got=%0d required=4", lat); end
    checks++;
    if (sum !== 32'h2 || carry !== 1'b0) begin
      failures++; $display("FAIL reset_mid_after_result: sum=%h carry=%b required 00000002/0", sum, carry);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    start = 1'b1; num1 = 32'h80000000; num2 = 32'h80000000; carry_in = 1'b0;
    tick();
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_done = (k == 4 || k == 9);
      checks++;
      if (done !== exp_done) begin
        failures++; $display("FAIL b2b_done_edge%0d: got=%b required=%b", k, done, exp_done);
      end
      if (k >= 4) begin
        checks++;
        if (sum !== 32'h0 || carry !== 1'b1) begin
          failures++; $display("FAIL b2b_result_edge%0d: sum=%h carry=%b required 00000000/1", k, sum, carry);
        end
      end
    end
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL b2b_idle_after: busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         ci;
    logic [W:0]   exp;
    int           lat, gap, spurious;
    spurious = 0;
    for (int op = 0; op < 1000; op++) begin
      a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
      if (op % 10 == 0) b = ~a;
      exp = ref_add(a, b, ci);
      start = 1'b1; num1 = a; num2 = b; carry_in = ci;
      tick();
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
        start = 1'($urandom_range(0, 1));
        num1 = $urandom; num2 = $urandom; carry_in = 1'($urandom_range(0, 1));
        tick();
        if (done) begin lat = c; break; end
      end
      start = 1'b0;
      checks++;
      if (lat !== 4) begin failures++; $display("FAIL rand_latency op%0d: got=%0d required=4", op, lat); end
      checks++;
      if ({carry, sum} !== exp) begin
        failures++;
        $display("FAIL rand_result op%0d: a=%h b=%h ci=%b got=%b_%h required=%b_%h",
                 op, a, b, ci, carry, sum, exp[W], exp[W-1:0]);
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        if (done || busy) spurious++;
      end
    end
    checks++;
    if (spurious !== 0) begin
      failures++; $display("FAIL rand_spurious: got=%0d idle cycles with done/busy required=0", spurious);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; num1 = '0; num2 = '0; carry_in = 1'b0;
    test_reset();
    test_ripple();
    test_carry_in();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
